// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the fetch front end.
// Also used by the store buffer.
package cpu_pkg;

  localparam logic [31:0] RESET_VEC = 32'hBFC00000;
  localparam logic [31:0] EXC_VEC   = 32'hBFC00380;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } ifq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with clear.
// Push while full is accepted only together with a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch address generator + instruction queue to ID.
// Define IFQ_BYPASS_EN to forward a response straight to out_* when empty.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VEC,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        exc_take,
  input  logic [31:0] exc_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e   r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_inflight;
  logic         r_req_epoch;
  logic         r_req_adel;
  logic         r_epoch;

  logic         w_redir;
  logic [31:0]  w_tgt;
  logic [31:0]  w_fpc;
  logic         w_misal;
  logic         w_run;
  logic         w_pop;
  logic         w_credit;
  logic         w_issue;
  logic         w_resp;
  logic         w_fpush;
  logic         w_fpop;
  logic         w_full;
  logic         w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t w_resp_e;
  fetch_entry_t w_head;
  fetch_entry_t w_out;

  assign w_redir  = exc_take | br_take;
  assign w_tgt    = exc_take ? exc_target : br_target;
  assign w_fpc    = w_redir ? w_tgt : r_pc;
  assign w_misal  = (w_fpc[1:0] != 2'b00);
  assign w_run    = (r_state == ST_RUN);
  assign w_pop    = out_valid && out_ready;
  // In-flight request owns a slot so its response can never be lost.
  assign w_credit = (!w_full && ((w_count + CW'(r_inflight)) < CW'(DEPTH)))
                  || w_pop;
  assign w_issue  = w_run && (w_redir || w_credit);

  assign inst_sram_en    = w_issue && !w_misal;
  assign inst_sram_addr  = w_fpc;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

  assign w_resp   = r_inflight && (r_req_epoch == r_epoch) && !w_redir;
  assign w_resp_e = '{pc:   r_req_pc,
                      inst: r_req_adel ? 32'b0 : inst_sram_rdata,
                      adel: r_req_adel};

`ifdef IFQ_BYPASS_EN
  assign out_valid = !w_empty || w_resp;
  assign w_out     = (w_empty && w_resp) ? w_resp_e : w_head;
  assign w_fpush   = w_resp && !(w_empty && out_ready);
`else
  assign out_valid = !w_empty;
  assign w_out     = w_head;
  assign w_fpush   = w_resp;
`endif
  assign w_fpop    = w_pop && !w_empty;

  assign out_pc   = w_out.pc;
  assign out_inst = w_out.inst;
  assign out_adel = w_out.adel;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_clr   (w_redir),
    .i_push  (w_fpush),
    .i_pop   (w_fpop),
    .i_wdata (w_resp_e),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_inflight  <= 1'b0;
      r_req_epoch <= 1'b0;
      r_req_adel  <= 1'b0;
      r_epoch     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
      r_inflight <= w_issue;
      if (w_redir) begin
        r_epoch <= ~r_epoch;
        r_pc    <= w_tgt;
      end
      if (w_issue) begin
        r_pc        <= w_fpc + PC_STEP;
        r_req_pc    <= w_fpc;
        r_req_epoch <= w_redir ? ~r_epoch : r_epoch;
        r_req_adel  <= w_misal;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized bench with a stream-level reference model.
// The model tracks the next PC ID should consume, and redirect targets.
module tb_if_fetch_queue;

  localparam logic [31:0] RST = 32'hBFC00000;
  localparam logic [31:0] EXC = 32'hBFC00380;
  localparam logic [31:0] BR  = 32'hBFC00100;
  localparam int          DEP = 4;
`ifdef IFQ_BYPASS_EN
  localparam int FIRST_LAT = 2;
`else
  localparam int FIRST_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        br_take;
  logic [31:0] br_target;
  logic        exc_take;
  logic [31:0] exc_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_iss;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        exp_adel;

  if_fetch_queue dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .br_take         (br_take),
    .br_target       (br_target),
    .exc_take        (exc_take),
    .exc_target      (exc_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_adel        (out_adel)
  );

  always #5 clk = ~clk;

  // SRAM model: word returned is the bitwise complement of its address.
  always @(posedge clk)
    if (inst_sram_en) inst_sram_rdata <= ~inst_sram_addr;

  always @(posedge clk or negedge resetn)
    if (!resetn) n_iss <= 0;
    else if (inst_sram_en) n_iss <= n_iss + 1;

  task automatic drive(input logic rdy, input logic br,
                       input logic [31:0] bt, input logic exc,
                       input logic [31:0] et);
    @(negedge clk);
    out_ready = rdy;
    br_take = br;
    br_target = bt;
    exc_take = exc;
    exc_target = et;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    out_ready = 1'b0;
    br_take = 1'b0;
    br_target = '0;
    exc_take = 1'b0;
    exc_target = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (inst_sram_en !== 1'b0) begin
      failures++; $display("FAIL reset_en got=%b exp=0", inst_sram_en);
    end
    checks++;
    if (inst_sram_addr !== RST) begin
      failures++; $display("FAIL reset_addr got=%h exp=%h", inst_sram_addr, RST);
    end
    checks++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0 || out_adel !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got pc=%h inst=%h adel=%b exp 0/0/0", out_pc, out_inst, out_adel);
    end
    checks++;
    if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin
      failures++;
      $display("FAIL reset_tie got wen=%h wdata=%h exp 0", inst_sram_wen, inst_sram_wdata);
    end
  endtask

  task automatic test_boot_stream;
    int first = -1;
    int acc0;
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (inst_sram_en !== 1'b0) begin
      failures++; $display("FAIL boot_en got=%b exp=0", inst_sram_en);
    end
    exp_pc = RST;
    n_acc = 0;
    acc0 = n_acc;
    for (int c = 1; c <= 20; c++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      if (c == 1) begin
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST) begin
          failures++;
          $display("FAIL first_req got en=%b addr=%h exp 1/%h", inst_sram_en, inst_sram_addr, RST);
        end
      end
      if (out_valid && first < 0) first = c;
      if (out_valid && out_ready) begin
        exp_adel = exp_pc[1:0] != 2'b00;
        exp_inst = exp_adel ? 32'h0 : ~exp_pc;
        checks++;
        if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
          failures++;
          $display("FAIL boot_stream got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                   out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
        end
        exp_pc += 32'd4;
        n_acc++;
      end
    end
    checks++;
    if (first != FIRST_LAT) begin
      failures++; $display("FAIL first_valid got=%0d exp=%0d", first, FIRST_LAT);
    end
    checks++;
    if (n_acc - acc0 != 21 - FIRST_LAT) begin
      failures++;
      $display("FAIL stream_rate got=%0d exp=%0d", n_acc - acc0, 21 - FIRST_LAT);
    end
  endtask

  task automatic test_stall_full;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      if (c >= 7) begin
        checks++;
        if (inst_sram_en !== 1'b0) begin
          failures++; $display("FAIL full_en c=%0d got=%b exp=0", c, inst_sram_en);
        end
      end
    end
    checks++;
    if (n_iss - n_acc != DEP) begin
      failures++; $display("FAIL full_count got=%0d exp=%0d", n_iss - n_acc, DEP);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL full_valid got=%b exp=1", out_valid);
    end
  endtask

  task automatic test_branch_flush;
    int acc0;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    checks++;
    if (inst_sram_en !== 1'b1) begin
      failures++; $display("FAIL pop_credit_en got=%b exp=1", inst_sram_en);
    end
    if (out_valid && out_ready) begin
      exp_adel = exp_pc[1:0] != 2'b00;
      exp_inst = exp_adel ? 32'h0 : ~exp_pc;
      checks++;
      if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
        failures++;
        $display("FAIL resume_stream got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                 out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
      end
      exp_pc += 32'd4;
      n_acc++;
    end
    drive(1'b0, 1'b1, BR, 1'b0, '0);
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== BR) begin
      failures++;
      $display("FAIL br_req got en=%b addr=%h exp 1/%h", inst_sram_en, inst_sram_addr, BR);
    end
    exp_pc = BR;
    acc0 = n_acc;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      if (out_valid && out_ready) begin
        exp_adel = exp_pc[1:0] != 2'b00;
        exp_inst = exp_adel ? 32'h0 : ~exp_pc;
        checks++;
        if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
          failures++;
          $display("FAIL br_stream got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                   out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
        end
        exp_pc += 32'd4;
        n_acc++;
      end
    end
    checks++;
    if (n_acc - acc0 < 9) begin
      failures++; $display("FAIL br_progress got=%0d exp>=9", n_acc - acc0);
    end
  endtask

  task automatic test_exc_priority;
    int acc0;
    drive(1'b1, 1'b1, BR, 1'b1, EXC);
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== EXC) begin
      failures++;
      $display("FAIL exc_req got en=%b addr=%h exp 1/%h", inst_sram_en, inst_sram_addr, EXC);
    end
    if (out_valid && out_ready) begin
      exp_adel = exp_pc[1:0] != 2'b00;
      exp_inst = exp_adel ? 32'h0 : ~exp_pc;
      checks++;
      if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
        failures++;
        $display("FAIL exc_pop got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                 out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
      end
      n_acc++;
    end
    exp_pc = EXC;
    acc0 = n_acc;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      if (out_valid && out_ready) begin
        exp_adel = exp_pc[1:0] != 2'b00;
        exp_inst = exp_adel ? 32'h0 : ~exp_pc;
        checks++;
        if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
          failures++;
          $display("FAIL exc_stream got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                   out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
        end
        exp_pc += 32'd4;
        n_acc++;
      end
    end
    checks++;
    if (n_acc - acc0 < 5) begin
      failures++; $display("FAIL exc_progress got=%0d exp>=5", n_acc - acc0);
    end
  endtask

  task automatic test_adel;
    int acc0;
    drive(1'b0, 1'b1, 32'hBFC00102, 1'b0, '0);
    checks++;
    if (inst_sram_en !== 1'b0) begin
      failures++; $display("FAIL adel_en got=%b exp=0", inst_sram_en);
    end
    exp_pc = 32'hBFC00102;
    acc0 = n_acc;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      checks++;
      if (inst_sram_en !== 1'b0) begin
        failures++; $display("FAIL adel_stream_en got=%b exp=0", inst_sram_en);
      end
      if (out_valid && out_ready) begin
        exp_adel = exp_pc[1:0] != 2'b00;
        exp_inst = exp_adel ? 32'h0 : ~exp_pc;
        checks++;
        if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
          failures++;
          $display("FAIL adel_stream got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                   out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
        end
        exp_pc += 32'd4;
        n_acc++;
      end
    end
    checks++;
    if (n_acc - acc0 < 3) begin
      failures++; $display("FAIL adel_progress got=%0d exp>=3", n_acc - acc0);
    end
  endtask

  task automatic test_random;
    int acc0 = n_acc;
    logic rdy, br, exc;
    logic [31:0] bt, et;
    for (int c = 0; c < 400; c++) begin
      int r = $urandom_range(0, 15);
      rdy = ($urandom_range(0, 3) != 0);
      br  = (r == 0) || (r == 2);
      exc = (r == 1) || (r == 2);
      bt  = $urandom & 32'hFFFF_FFFC;
      et  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) bt[1] = 1'b1;
      drive(rdy, br, bt, exc, et);
      checks++;
      if (inst_sram_en && inst_sram_addr[1:0] != 2'b00) begin
        failures++; $display("FAIL rand_align addr=%h exp low bits 0", inst_sram_addr);
      end
      if (out_valid && out_ready) begin
        exp_adel = exp_pc[1:0] != 2'b00;
        exp_inst = exp_adel ? 32'h0 : ~exp_pc;
        checks++;
        if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
          failures++;
          $display("FAIL rand_stream c=%0d got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                   c, out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
        end
        exp_pc += 32'd4;
        n_acc++;
      end
      if (exc) exp_pc = et;
      else if (br) exp_pc = bt;
    end
    checks++;
    if (n_acc - acc0 < 100) begin
      failures++; $display("FAIL rand_progress got=%0d exp>=100", n_acc - acc0);
    end
  endtask

  task automatic test_reset_midstream;
    int acc0;
    for (int c = 0; c < 8; c++) drive(1'b0, 1'b0, '0, 1'b0, '0);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid);
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || inst_sram_en !== 1'b0 || inst_sram_addr !== RST) begin
      failures++;
      $display("FAIL async_reset got valid=%b en=%b addr=%h exp 0/0/%h",
               out_valid, inst_sram_en, inst_sram_addr, RST);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (inst_sram_en !== 1'b0) begin
      failures++; $display("FAIL reboot_en got=%b exp=0", inst_sram_en);
    end
    exp_pc = RST;
    acc0 = n_acc;
    for (int c = 1; c <= 10; c++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      if (c == 1) begin
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST) begin
          failures++;
          $display("FAIL reboot_req got en=%b addr=%h exp 1/%h", inst_sram_en, inst_sram_addr, RST);
        end
      end
      if (out_valid && out_ready) begin
        exp_adel = exp_pc[1:0] != 2'b00;
        exp_inst = exp_adel ? 32'h0 : ~exp_pc;
        checks++;
        if (out_pc !== exp_pc || out_inst !== exp_inst || out_adel !== exp_adel) begin
          failures++;
          $display("FAIL reboot_stream got pc=%h inst=%h adel=%b exp pc=%h inst=%h adel=%b",
                   out_pc, out_inst, out_adel, exp_pc, exp_inst, exp_adel);
        end
        exp_pc += 32'd4;
        n_acc++;
      end
    end
    checks++;
    if (n_acc - acc0 != 11 - FIRST_LAT) begin
      failures++;
      $display("FAIL reboot_rate got=%0d exp=%0d", n_acc - acc0, 11 - FIRST_LAT);
    end
  endtask

  initial begin
    test_reset;
    test_boot_stream;
    test_stall_full;
    test_branch_flush;
    test_exc_priority;
    test_adel;
    test_random;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
